// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic inter-stage pipeline registers:
// standard bundle widths, control-bundle field layout, bubble value and occupancy state.
package pipe_pkg;

  localparam int unsigned IF_ID_DATA_W  = 64;
  localparam int unsigned IF_ID_CTRL_W  = 1;
  localparam int unsigned ID_EX_DATA_W  = 192;
  localparam int unsigned ID_EX_CTRL_W  = 18;
  localparam int unsigned EX_MEM_DATA_W = 128;
  localparam int unsigned EX_MEM_CTRL_W = 7;
  localparam int unsigned MEM_WB_DATA_W = 96;
  localparam int unsigned MEM_WB_CTRL_W = 3;

  // Control bundle layout, LSB first; widths sum to ID_EX_CTRL_W.
  localparam int unsigned CTRL_EXTOP_O    = 0;
  localparam int unsigned CTRL_LUIOP_O    = 1;
  localparam int unsigned CTRL_ALUOP_O    = 2;
  localparam int unsigned CTRL_ALUOP_W    = 4;
  localparam int unsigned CTRL_ALUSRCA_O  = 6;
  localparam int unsigned CTRL_ALUSRC_O   = 7;
  localparam int unsigned CTRL_REGDST_O   = 8;
  localparam int unsigned CTRL_REGDST_W   = 2;
  localparam int unsigned CTRL_MEMREAD_O  = 10;
  localparam int unsigned CTRL_MEMWR_O    = 11;
  localparam int unsigned CTRL_BRANCH_O   = 12;
  localparam int unsigned CTRL_BRANCH_W   = 3;
  localparam int unsigned CTRL_MEMTOREG_O = 15;
  localparam int unsigned CTRL_MEMTOREG_W = 2;
  localparam int unsigned CTRL_REGWR_O    = 17;

  // No register write, no memory access, no branch.
  localparam logic [ID_EX_CTRL_W-1:0] NOP_CTRL = '0;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_e;

  function automatic logic [1:0] level_of(input skid_state_e st);
    case (st)
      ST_ONE:  level_of = 2'd1;
      ST_TWO:  level_of = 2'd2;
      default: level_of = 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/pipe_stage_skid_if.sv
// Valid/ready handshake bundle carrying one datapath and one control word.
interface pipe_stage_skid_if #(
  parameter int unsigned DATA_W = 192,
  parameter int unsigned CTRL_W = 18
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] data;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output data, output ctrl, input ready);
  modport slave  (input valid, input data, input ctrl, output ready);
endinterface

// File: rtl/pipe_slot.sv
// Single-entry bundle register with load and clear-to-bubble; clear beats load.
module pipe_slot #(
  parameter int unsigned      DATA_W = 192,
  parameter int unsigned      CTRL_W = 18,
  parameter logic [CTRL_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load_i,
  input  logic              clear_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  output logic [DATA_W-1:0] data_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  logic [DATA_W-1:0] data_q;
  logic [CTRL_W-1:0] ctrl_q;

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      data_q <= '0;
      ctrl_q <= BUBBLE;
    end else if (load_i) begin
      data_q <= data_i;
      ctrl_q <= ctrl_i;
    end
  end

  assign data_o = data_q;
  assign ctrl_o = ctrl_q;

endmodule

// File: rtl/pipe_stage_skid.sv
// Elastic pipeline register: 2-entry skid buffer with valid/ready handshake,
// registered in_ready (no out_ready -> in_ready path) and flush to bubble.
module pipe_stage_skid
  import pipe_pkg::*;
#(
  parameter int unsigned       DATA_W      = 192,
  parameter int unsigned       CTRL_W      = 18,
  parameter logic [CTRL_W-1:0] BUBBLE_CTRL = CTRL_W'(NOP_CTRL)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  pipe_stage_skid_if.slave         in_bus,
  pipe_stage_skid_if.master        out_bus,
  output logic [1:0]               level
);

  skid_state_e state_q;

  logic              accept, drain;
  logic              main_load, main_clear, skid_load, skid_clear;
  logic [DATA_W-1:0] main_data_d, skid_data;
  logic [CTRL_W-1:0] main_ctrl_d, skid_ctrl;

  assign in_bus.ready  = (state_q != ST_TWO) && !flush;
  assign out_bus.valid = (state_q != ST_EMPTY);
  assign accept        = in_bus.valid && in_bus.ready;
  assign drain         = out_bus.valid && out_bus.ready;
  assign level         = level_of(state_q);

  // Storage only loads on accept (which needs in_valid) or skid->main moves,
  // so an idle input bus never reaches the registers.
  always_comb begin
    main_load   = 1'b0;
    skid_load   = 1'b0;
    main_clear  = flush;
    skid_clear  = flush;
    main_data_d = in_bus.data;
    main_ctrl_d = in_bus.ctrl;
    case (state_q)
      ST_EMPTY: main_load = accept;
      ST_ONE: begin
        main_load  = accept && drain;
        skid_load  = accept && !drain;
        main_clear = flush || (drain && !accept);
      end
      ST_TWO: begin
        main_load   = drain;
        skid_clear  = flush || drain;
        main_data_d = skid_data;
        main_ctrl_d = skid_ctrl;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      state_q <= ST_EMPTY;
    end else begin
      case (state_q)
        ST_EMPTY: if (accept) state_q <= ST_ONE;
        ST_ONE: begin
          if (accept && !drain)      state_q <= ST_TWO;
          else if (!accept && drain) state_q <= ST_EMPTY;
        end
        ST_TWO:   if (drain) state_q <= ST_ONE;
        default:  state_q <= ST_EMPTY;
      endcase
    end
  end

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .BUBBLE (BUBBLE_CTRL)
  ) u_main (
    .clk     (clk),
    .reset   (reset),
    .load_i  (main_load),
    .clear_i (main_clear),
    .data_i  (main_data_d),
    .ctrl_i  (main_ctrl_d),
    .data_o  (out_bus.data),
    .ctrl_o  (out_bus.ctrl)
  );

  pipe_slot #(
    .DATA_W (DATA_W),
    .CTRL_W (CTRL_W),
    .BUBBLE ('0)
  ) u_skid (
    .clk     (clk),
    .reset   (reset),
    .load_i  (skid_load),
    .clear_i (skid_clear),
    .data_i  (in_bus.data),
    .ctrl_i  (in_bus.ctrl),
    .data_o  (skid_data),
    .ctrl_o  (skid_ctrl)
  );

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Self-checking bench: the stage is modelled as a 2-deep FIFO that blocks input on flush.
module tb_pipe_stage_skid;
  import pipe_pkg::*;

  localparam int unsigned DW = 192;
  localparam int unsigned CW = 18;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       flush = 1'b0;
  logic [1:0] level;

  always #5 clk = ~clk;

  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) in_bus ();
  pipe_stage_skid_if #(.DATA_W(DW), .CTRL_W(CW)) out_bus ();

  pipe_stage_skid #(
    .DATA_W      (DW),
    .CTRL_W      (CW),
    .BUBBLE_CTRL (NOP_CTRL)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .flush   (flush),
    .in_bus  (in_bus),
    .out_bus (out_bus),
    .level   (level)
  );

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } entry_t;

  entry_t q[$];
  int     checks = 0;
  int     errors = 0;

  task automatic check_val(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                      input logic ordy, input logic fl, input logic rst);
    logic   exp_rdy;
    entry_t e;
    in_bus.valid  = iv;
    in_bus.data   = d;
    in_bus.ctrl   = c;
    out_bus.ready = ordy;
    flush         = fl;
    reset         = rst;
    #1;
    exp_rdy = (q.size() < 2) && !fl;
    if (!rst) check_val("in_ready", {255'd0, in_bus.ready}, {255'd0, exp_rdy});
    @(posedge clk);
    if (rst) begin
      q.delete();
    end else begin
      if (q.size() > 0 && ordy) void'(q.pop_front());
      if (fl) q.delete();
      else if (iv && exp_rdy) begin
        e.d = d;
        e.c = c;
        q.push_back(e);
      end
    end
    #1;
    check_val("out_valid", {255'd0, out_bus.valid}, {255'd0, q.size() > 0});
    check_val("level", {254'd0, level}, 256'(q.size()));
    check_val("out_data", {64'd0, out_bus.data}, (q.size() > 0) ? {64'd0, q[0].d} : 256'd0);
    check_val("out_ctrl", {238'd0, out_bus.ctrl}, (q.size() > 0) ? {238'd0, q[0].c} : {238'd0, NOP_CTRL});
  endtask

  function automatic logic [DW-1:0] rand_data();
    return {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  initial begin
    logic [DW-1:0] a5;
    logic          iv, ordy, fl, rst;
    int unsigned   rdy_bias;
    a5 = {24{8'hA5}};

    // reset with input offered, then stream 1..4 with downstream always ready
    step(1'b1, a5, 18'h3FFFF, 1'b0, 1'b0, 1'b1);
    step(1'b1, a5, 18'h3FFFF, 1'b0, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) step(1'b1, DW'(i), CW'(i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // back-pressure: fill to two, 12 must be refused, then drain
    step(1'b1, DW'(10), 18'h10, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(11), 18'h11, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(12), 18'h12, 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // flush while full with a new input offered
    step(1'b1, DW'(20), 18'h20, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(21), 18'h21, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(22), 18'h22, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // simultaneous accept and drain while holding one entry
    step(1'b1, DW'(30), 18'h30, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(31), 18'h31, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // reset while full, then reset together with flush while full
    step(1'b1, DW'(40), 18'h40, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(41), 18'h41, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(42), 18'h42, 1'b0, 1'b0, 1'b1);
    step(1'b1, DW'(50), 18'h50, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(51), 18'h51, 1'b0, 1'b0, 1'b0);
    step(1'b1, DW'(52), 18'h52, 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b0, 1'b0, 1'b0);

    // randomised traffic with varying downstream readiness
    for (int i = 0; i < 10000; i++) begin
      rdy_bias = (i / 1000) % 4;
      iv   = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 3) < rdy_bias + 1);
      fl   = ($urandom_range(0, 63) == 0);
      rst  = ($urandom_range(0, 511) == 0);
      step(iv, rand_data(), CW'($urandom()), ordy, fl, rst);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
Name: pipe_stage_skid

Overview:
- Parametrised, elastic successor to the fixed inter-stage pipeline registers (IF/ID, ID/EX, EX/MEM, MEM/WB).
- Carries one datapath bundle and one control bundle per entry through a 2-entry skid buffer.
- Adds a valid/ready handshake, stall back-pressure without a combinational ready path, and flush with bubble insertion.
- Sits between any two CPU stages. Hazard logic drives `flush`; downstream stall logic drives `out_ready`.

Parameters:
- DATA_W, 192, width of the datapath bundle (e.g. two operands, PC, immediates, opcode/rs/rt/rd/shamt/funct).
- CTRL_W, 18, width of the control bundle (ExtOp, LuiOp, ALUOp, ALUSrcA, ALUSrc, RegDst, MemRead, MemWr, Branch, MemtoReg, RegWr).
- BUBBLE_CTRL, {CTRL_W{1'b0}}, control value presented whenever the output slot holds no valid entry (NOP: no write, no memory access, no branch).

Ports:
- clk, in, 1, clock; all state updates on the rising edge.
- reset, in, 1, synchronous active-high reset, sampled on the rising edge of clk.
- flush, in, 1, discard all held entries and any same-cycle input.
- in_valid, in, 1, upstream entry present.
- in_ready, out, 1, stage can accept; equals ~skid_valid & ~flush.
- in_data, in, DATA_W, upstream datapath bundle.
- in_ctrl, in, CTRL_W, upstream control bundle.
- out_valid, out, 1, output slot holds a valid entry.
- out_ready, in, 1, downstream consumes out_* this cycle.
- out_data, out, DATA_W, registered datapath bundle.
- out_ctrl, out, CTRL_W, registered control bundle; equals BUBBLE_CTRL when out_valid=0.
- level, out, 2, occupancy 0..2.

Behaviour:
- Storage: main register (drives out_*) plus skid register. State is EMPTY (level 0), ONE (level 1, main only) or TWO (level 2, main and skid).
- accept = in_valid & in_ready.
- drain = out_valid & out_ready.
- Priority, highest first: reset, then flush, then normal operation.
- Reset (synchronous):
  - state EMPTY, out_valid=0, in_ready=1 (after reset deasserts), level=0.
  - out_data=0, out_ctrl=BUBBLE_CTRL, skid contents=0.
- Flush (no reset):
  - Next state EMPTY; out_data<=0; out_ctrl<=BUBBLE_CTRL.
  - in_ready is low during the flush cycle, so no input is accepted.
  - A drain in the same cycle still counts as consumed downstream.
- Transitions:
  - EMPTY: accept → ONE, main<=in. No accept → stay EMPTY.
  - ONE, accept & drain → ONE, main<=in.
  - ONE, accept & !drain → TWO, skid<=in, main holds.
  - ONE, !accept & drain → EMPTY, main data<=0, ctrl<=BUBBLE_CTRL.
  - ONE, neither → hold.
  - TWO: in_ready=0. drain → ONE, main<=skid. Otherwise hold.
- Latency: an input accepted into an empty or draining stage appears on out_* the next cycle (1 cycle). An entry through the skid path takes 2 or more cycles.
- Ordering is strictly FIFO; no entry is duplicated or dropped except by flush.
- in_ready depends only on registered state and flush. There is never a combinational path from out_ready to in_ready.
- While out_valid=1 && out_ready=0, out_data and out_ctrl are stable.
- level = number of valid entries; it never exceeds 2.
- X on in_data/in_ctrl while in_valid=0 must not propagate into storage.

Decomposition:
- Shared package pipe_pkg holds:
  - localparams for the standard bundle widths (ID_EX_DATA_W, ID_EX_CTRL_W, etc.);
  - field offset constants for packing and unpacking the control bundle;
  - NOP_CTRL, used as the BUBBLE_CTRL value;
  - the state encoding typedef (EMPTY/ONE/TWO).
- One natural sub-module: pipe_slot, a single-entry register with load, clear-to-bubble and reset. It is instantiated twice, once as main and once as skid.

Test Plan:
- Reset: assert reset with in_valid=1 and in_data=0xA5.. → out_valid=0, out_ctrl=0, level=0, in_ready=1 after release. Stream 4 entries (data 1,2,3,4) with out_ready=1 → out_data 1,2,3,4 on consecutive cycles, each 1 cycle after acceptance.
- Back-pressure: out_ready=0 with entries 10,11 offered → level=2, in_ready=0, out_data=10 stable. Then out_ready=1 for 2 cycles → 10 then 11 emerge; level returns to 0.
- Flush while TWO (entries 20,21) with in_valid=1 and data 22 → next cycle out_valid=0, out_ctrl=BUBBLE_CTRL, out_data=0, level=0; 22 is not accepted.
- Simultaneous accept and drain in ONE (holding 30, input 31) → next cycle out_data=31, level=1.
- Reset asserted mid-operation while TWO → next cycle EMPTY, outputs at reset values. Flush and reset together → reset values.
- Randomised valid/ready with a reference FIFO model over 10k cycles → no loss, duplication or reordering; in_ready never high when level=2.
